// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and geometry for the cache-line to burst-memory adaptor.
// Optional watchdog macro: CACHELINE_ADAPTOR_TIMEOUT_EN.
package cacheline_adaptor_types;

  localparam int BEATS          = 4;
  localparam int BEAT_W         = 64;
  localparam int LINE_W         = BEATS * BEAT_W;
  localparam int OFFSET_BITS    = 5;
  localparam int CNT_W          = $clog2(BEATS);
  localparam int TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/cacheline_adaptor_line_buffer.sv
// 256-bit line register: full-line load, beat-indexed write, beat-indexed read.
// Used by cacheline_adaptor (optional watchdog macro: CACHELINE_ADAPTOR_TIMEOUT_EN).
module line_buffer
  import cacheline_adaptor_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [LINE_W-1:0] load_line,
  input  logic              wr_en,
  input  logic [CNT_W-1:0]  wr_idx,
  input  logic [BEAT_W-1:0] wr_beat,
  input  logic [CNT_W-1:0]  rd_idx,
  output logic [BEAT_W-1:0] rd_beat,
  output logic [LINE_W-1:0] line
);

  logic [BEATS-1:0][BEAT_W-1:0] buf_q;

  // NOTE: the line storage is reset on purpose, because pmem_rdata and
  // burst_wdata are observed straight from it and must read zero after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q <= '0;
    end else if (load_en) begin
      buf_q <= load_line;
    end else if (wr_en) begin
      buf_q[wr_idx] <= wr_beat;
    end
  end

  assign rd_beat = buf_q[rd_idx];
  assign line    = buf_q;

endmodule

// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit cache line port to a 4-beat x 64-bit burst memory.
// Optional stall watchdog enabled by defining CACHELINE_ADAPTOR_TIMEOUT_EN.
module cacheline_adaptor
  import cacheline_adaptor_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pmem_address,
  output logic [LINE_W-1:0] pmem_rdata,
  input  logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_read,
  input  logic              pmem_write,
  output logic              pmem_resp,
  output logic [31:0]       burst_address,
  output logic              burst_read,
  output logic              burst_write,
  output logic [BEAT_W-1:0] burst_wdata,
  input  logic [BEAT_W-1:0] burst_rdata,
  input  logic              burst_resp,
  output logic              timeout_err
);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               last_beat;
  logic               stall_hit;
  logic [31:0]        aligned_addr;
  logic [OFFSET_BITS-1:0] unused_addr_bits;

  assign aligned_addr     = {pmem_address[31:OFFSET_BITS], OFFSET_BITS'(0)};
  assign unused_addr_bits = pmem_address[OFFSET_BITS-1:0];
  assign last_beat        = (cnt_q == CNT_W'(BEATS - 1));

  line_buffer u_line_buffer (
    .clk       (clk),
    .rst       (rst),
    .load_en   (state_q == IDLE && !pmem_read && pmem_write),
    .load_line (pmem_wdata),
    .wr_en     (state_q == READ && burst_resp),
    .wr_idx    (cnt_q),
    .wr_beat   (burst_rdata),
    .rd_idx    (cnt_q),
    .rd_beat   (burst_wdata),
    .line      (pmem_rdata)
  );

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  logic [7:0] stall_q;
  logic       busy;

  assign busy      = (state_q == READ) || (state_q == WRITE);
  assign stall_hit = busy && !burst_resp && (stall_q == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (!busy || burst_resp || stall_hit) stall_q <= '0;
      else                                  stall_q <= stall_q + 8'd1;
      if (stall_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign stall_hit   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // NOTE: every register here uses <= so all state advances from the same
  // pre-edge snapshot; blocking assignments would make order matter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      burst_address <= '0;
      burst_read    <= 1'b0;
      burst_write   <= 1'b0;
      pmem_resp     <= 1'b0;
    end else begin
      pmem_resp <= 1'b0;
      case (state_q)
        IDLE: begin
          // Read wins if the cache illegally raises both requests.
          if (pmem_read) begin
            state_q       <= READ;
            burst_address <= aligned_addr;
            burst_read    <= 1'b1;
          end else if (pmem_write) begin
            state_q       <= WRITE;
            burst_address <= aligned_addr;
            burst_write   <= 1'b1;
          end
        end
        READ, WRITE: begin
          if (burst_resp) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_beat) begin
              state_q     <= RESP;
              cnt_q       <= '0;
              burst_read  <= 1'b0;
              burst_write <= 1'b0;
              pmem_resp   <= 1'b1;
            end
          end else if (stall_hit) begin
            state_q     <= RESP;
            cnt_q       <= '0;
            burst_read  <= 1'b0;
            burst_write <= 1'b0;
            pmem_resp   <= 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed, table-driven bench for cacheline_adaptor with hand-written
// reset and watchdog (CACHELINE_ADAPTOR_TIMEOUT_EN) sequences.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_rdata;
  logic [255:0] pmem_wdata;
  logic         pmem_read;
  logic         pmem_write;
  logic         pmem_resp;
  logic [31:0]  burst_address;
  logic         burst_read;
  logic         burst_write;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;
  logic         timeout_err;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  cacheline_adaptor dut (
    .clk           (clk),
    .rst           (rst),
    .pmem_address  (pmem_address),
    .pmem_rdata    (pmem_rdata),
    .pmem_wdata    (pmem_wdata),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_resp     (pmem_resp),
    .burst_address (burst_address),
    .burst_read    (burst_read),
    .burst_write   (burst_write),
    .burst_wdata   (burst_wdata),
    .burst_rdata   (burst_rdata),
    .burst_resp    (burst_resp)
    ,.timeout_err  (timeout_err)
  );

  typedef struct {
    string            name;
    bit               rd;
    bit               wr;
    logic [31:0]      addr;
    logic [3:0][63:0] beats;
    int               stall_at;
    int               stall_len;
    logic [31:0]      exp_addr;
    bit               exp_read;
    int               exp_cycles;
  } vec_t;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input bit rd, input bit wr,
                              input logic [31:0] addr, input logic [3:0][63:0] beats,
                              input int stall_at, input int stall_len,
                              input logic [31:0] exp_addr, input bit exp_read,
                              input int exp_cycles);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.addr = addr; v.beats = beats;
    v.stall_at = stall_at; v.stall_len = stall_len;
    v.exp_addr = exp_addr; v.exp_read = exp_read; v.exp_cycles = exp_cycles;
    return v;
  endfunction

  // Acts as the cache (request held until pmem_resp) and as burst memory.
  task automatic run_txn(input vec_t v);
    int          cyc = 0, beat = 0, stalls = 0, resp_cnt = 0, tail = 0, cycles = 0;
    bit          got_resp = 0, held_ok = 1, wrong_kind = 0, wdata_ok = 1, addr_stable = 1;
    bit          active;
    logic [31:0] addr_obs = '0;
    logic [255:0] rdata_at_resp = '0;
    @(negedge clk);
    pmem_read = v.rd; pmem_write = v.wr; pmem_address = v.addr; pmem_wdata = v.beats;
    while (tail < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        addr_obs     = burst_address;
        pmem_address = ~v.addr;
      end
      burst_resp = 1'b0; burst_rdata = '0;
      if (v.exp_read ? burst_write : burst_read) wrong_kind = 1;
      if (got_resp) begin
        tail++;
        if (pmem_resp) resp_cnt++;
        burst_resp = 1'b1; burst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      end else if (pmem_resp) begin
        got_resp = 1; resp_cnt++; cycles = cyc + 1; rdata_at_resp = pmem_rdata;
        if (burst_read || burst_write) held_ok = 0;
        pmem_read = 1'b0; pmem_write = 1'b0;
        burst_resp = 1'b1; burst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      end else begin
        active = v.exp_read ? burst_read : burst_write;
        if (!active) held_ok = 0;
        if (burst_address !== addr_obs) addr_stable = 0;
        if (active && beat < 4) begin
          if (!v.exp_read && burst_wdata !== v.beats[beat]) wdata_ok = 0;
          if (beat == v.stall_at && stalls < v.stall_len) stalls++;
          else begin
            burst_resp = 1'b1; burst_rdata = v.beats[beat]; beat++;
          end
        end
      end
    end
    burst_resp = 1'b0;
    pmem_read = 1'b0; pmem_write = 1'b0;
    check({v.name, ".burst_address"}, addr_obs, v.exp_addr);
    check({v.name, ".addr_stable"}, addr_stable, 1);
    check({v.name, ".resp_count"}, resp_cnt, 1);
    check({v.name, ".cycles"}, cycles, v.exp_cycles);
    check({v.name, ".burst_held"}, held_ok, 1);
    check({v.name, ".wrong_burst"}, wrong_kind, 0);
    if (v.exp_read) begin
      check({v.name, ".rdata_at_resp"}, rdata_at_resp, v.beats);
      check({v.name, ".rdata_held"}, pmem_rdata, v.beats);
    end else begin
      check({v.name, ".wdata_beats"}, wdata_ok, 1);
    end
  endtask

  vec_t vecs[6];
  logic [3:0][63:0] rd_line, wr_line, alt_line;

  initial begin
    rd_line  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    wr_line  = {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
                64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A};
    alt_line = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                64'h5A5A_5A5A_A5A5_A5A5, 64'h0F0F_F0F0_00FF_FF00};
    vecs[0] = mk("rd_b2b",    1, 0, 32'h0000_1234, rd_line,  0, 0, 32'h0000_1220, 1, 6);
    vecs[1] = mk("rd_stall",  1, 0, 32'h0000_1234, rd_line,  2, 3, 32'h0000_1220, 1, 9);
    vecs[2] = mk("wr_b2b",    0, 1, 32'h8000_00E0, wr_line,  0, 0, 32'h8000_00E0, 0, 6);
    vecs[3] = mk("wr_stall",  0, 1, 32'hFFFF_FFFF, wr_line,  0, 2, 32'hFFFF_FFE0, 0, 8);
    vecs[4] = mk("rd_and_wr", 1, 1, 32'h0000_0047, alt_line, 0, 0, 32'h0000_0040, 1, 6);
    vecs[5] = mk("rd_late",   1, 0, 32'h0000_001F, alt_line, 3, 1, 32'h0000_0000, 1, 7);

    rst = 1'b0;
    pmem_address = '0; pmem_wdata = '0; pmem_read = 1'b0; pmem_write = 1'b0;
    burst_rdata = '0; burst_resp = 1'b0;
    #12;
    check("rst.burst_address", burst_address, 0);
    check("rst.burst_read", burst_read, 0);
    check("rst.burst_write", burst_write, 0);
    check("rst.burst_wdata", burst_wdata, 0);
    check("rst.pmem_resp", pmem_resp, 0);
    check("rst.pmem_rdata", pmem_rdata, 0);
    check("rst.timeout_err", timeout_err, 0);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Reset in the middle of a read burst, after two beats.
    @(negedge clk); pmem_read = 1'b1; pmem_address = 32'h0000_2000;
    @(negedge clk); burst_resp = 1'b1; burst_rdata = 64'h9999_0000_0000_0001;
    @(negedge clk); burst_rdata = 64'h9999_0000_0000_0002;
    @(negedge clk); burst_resp = 1'b0;
    check("mid.burst_read_before_rst", burst_read, 1);
    #2 rst = 1'b0;
    #1;
    check("mid.burst_read_async", burst_read, 0);
    check("mid.pmem_resp", pmem_resp, 0);
    check("mid.pmem_rdata_cleared", pmem_rdata, 0);
    pmem_read = 1'b0;
    @(negedge clk);
    check("mid.pmem_resp_in_rst", pmem_resp, 0);
    rst = 1'b1;
    run_txn(mk("after_rst", 1, 0, 32'h0000_2010, alt_line, 1, 2, 32'h0000_2000, 1, 8));

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    begin
      int to_cyc = 0, to_resp = 0, to_at = 0;
      @(negedge clk); pmem_read = 1'b1; pmem_address = 32'h0000_3000; burst_resp = 1'b0;
      repeat (300) begin
        @(negedge clk);
        to_cyc++;
        if (pmem_resp) begin
          to_resp++; to_at = to_cyc; pmem_read = 1'b0;
        end
      end
      check("to.resp_count", to_resp, 1);
      check("to.resp_cycle", to_at, 256);
      check("to.timeout_err", timeout_err, 1);
      check("to.burst_read_low", burst_read, 0);
      run_txn(mk("to_next", 1, 0, 32'h0000_3000, rd_line, 0, 0, 32'h0000_3000, 1, 6));
      check("to.err_sticky", timeout_err, 1);
      @(negedge clk); rst = 1'b0;
      #1 check("to.err_cleared", timeout_err, 0);
      @(negedge clk); rst = 1'b1;
    end
`else
    check("timeout_err_off", timeout_err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
